// File: rtl/lsu_sram_bridge.sv
// Load/store bridge between the execute stage and a byte-strobed data SRAM port.
// One access in flight; handles lane placement, extension and misalignment errors.
module lsu_sram_bridge #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [4:0]          req_rd,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic [4:0]          resp_rd,
   output logic                resp_ale,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [4:0]          rd_q, rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ale_q, ale_d;

   logic [OFF_W-1:0]    req_off;
   logic                misaligned;
   logic [STRB_W-1:0]   acc_strb;
   logic [DATA_W-1:0]   acc_wdata;
   logic [DATA_W-1:0]   shifted;
   logic [DATA_W-1:0]   load_mask;
   logic                load_sign;
   logic [DATA_W-1:0]   load_val;

   // Request decode: alignment, byte strobes and lane-replicated store data.
   always_comb begin
      req_off    = req_addr[OFF_W-1:0];
      misaligned = 1'b0;
      acc_strb   = '1;
      acc_wdata  = req_wdata;
      case (req_size)
         2'd0: begin
            acc_strb  = STRB_W'(1) << req_off;
            acc_wdata = {STRB_W{req_wdata[7:0]}};
         end
         2'd1: begin
            misaligned = req_addr[0];
            acc_strb   = STRB_W'(3) << req_off;
            acc_wdata  = {(DATA_W/16){req_wdata[15:0]}};
         end
         2'd2: begin
            misaligned = |req_addr[1:0];
            acc_strb   = STRB_W'(15) << req_off;
            acc_wdata  = {(DATA_W/32){req_wdata[31:0]}};
         end
         default: begin
            misaligned = (DATA_W == 32) || (|req_addr[2:0]);
         end
      endcase
   end

   // Load path: bring the addressed lane down to bit 0, then mask and extend.
   always_comb begin
      shifted   = mem_rdata >> {off_q, 3'b000};
      load_mask = '1;
      load_sign = 1'b0;
      case (size_q)
         2'd0: begin
            load_mask = DATA_W'(8'hFF);
            load_sign = shifted[7];
         end
         2'd1: begin
            load_mask = DATA_W'(16'hFFFF);
            load_sign = shifted[15];
         end
         2'd2: begin
            load_mask = DATA_W'(32'hFFFF_FFFF);
            load_sign = shifted[31];
         end
         default: ;
      endcase
      load_val = (shifted & load_mask) | ((load_sign && !uns_q) ? ~load_mask : '0);
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      off_d   = off_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      ale_d   = ale_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               off_d   = req_off;
               rd_d    = req_rd;
               addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               wdata_d = acc_wdata;
               wstrb_d = req_we ? acc_strb : '0;
               rdata_d = '0;
               ale_d   = misaligned;
               state_d = misaligned ? RESP : ADDR;
            end
         end
         ADDR: begin
            if (mem_addr_ok) state_d = DATA;
         end
         DATA: begin
            if (mem_data_ok) begin
               rdata_d = we_q ? '0 : load_val;
               state_d = RESP;
            end
         end
         default: begin
            if (resp_ready) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         off_q   <= '0;
         rd_q    <= 5'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         ale_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         ale_q   <= ale_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign mem_req    = (state_q == ADDR);
   assign mem_we     = mem_req & we_q;
   assign mem_wstrb  = mem_req ? wstrb_q : '0;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_rd    = rd_q;
   assign resp_ale   = ale_q;

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Randomised and directed bench for lsu_sram_bridge, 32-bit and 64-bit instances
// side by side, checked against an arithmetic reference model.
module tb_lsu_sram_bridge;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // Index 0 drives the DATA_W=32 instance, index 1 the DATA_W=64 instance.
   logic [1:0]        req_valid = '0, req_we = '0, req_unsigned = '0;
   logic [1:0]        resp_ready = '0, mem_addr_ok = '0, mem_data_ok = '0;
   logic [1:0][1:0]   req_size = '0;
   logic [1:0][31:0]  req_addr = '0;
   logic [1:0][63:0]  req_wdata = '0, mem_rdata = '0;
   logic [1:0][4:0]   req_rd = '0;

   logic [1:0]        req_ready, resp_valid, resp_ale, mem_req, mem_we;
   logic [1:0][4:0]   resp_rd;
   logic [1:0][31:0]  mem_addr;
   logic [31:0]       resp_rdata_32, mem_wdata_32;
   logic [3:0]        mem_wstrb_32;
   logic [63:0]       resp_rdata_64, mem_wdata_64;
   logic [7:0]        mem_wstrb_64;

   lsu_sram_bridge #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0][31:0]), .req_rd(req_rd[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata_32),
      .resp_rd(resp_rd[0]), .resp_ale(resp_ale[0]),
      .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_wstrb(mem_wstrb_32),
      .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata_32),
      .mem_addr_ok(mem_addr_ok[0]), .mem_data_ok(mem_data_ok[0]),
      .mem_rdata(mem_rdata[0][31:0])
   );

   lsu_sram_bridge #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_rd(req_rd[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata_64),
      .resp_rd(resp_rd[1]), .resp_ale(resp_ale[1]),
      .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_wstrb(mem_wstrb_64),
      .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata_64),
      .mem_addr_ok(mem_addr_ok[1]), .mem_data_ok(mem_data_ok[1]),
      .mem_rdata(mem_rdata[1])
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] o_rdata(input int d);
      return (d == 1) ? resp_rdata_64 : {32'd0, resp_rdata_32};
   endfunction
   function automatic logic [63:0] o_wdata(input int d);
      return (d == 1) ? mem_wdata_64 : {32'd0, mem_wdata_32};
   endfunction
   function automatic logic [63:0] o_wstrb(input int d);
      return (d == 1) ? {56'd0, mem_wstrb_64} : {60'd0, mem_wstrb_32};
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [63:0] dmask(input int dwid);
      return (dwid == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] exp_load(input int dwid, input int nb, input bit uns,
                                            input int off, input logic [63:0] raw);
      logic [63:0] v;
      int bits;
      bits = 8 * nb;
      v = (raw & dmask(dwid)) >> (8 * off);
      if (bits < 64) v = v & ((64'd1 << bits) - 64'd1);
      if (!uns && bits < dwid && v[bits-1]) v = (v - (64'd1 << bits)) & dmask(dwid);
      return v;
   endfunction

   function automatic logic [63:0] exp_strb(input int nbw, input int nb, input int off);
      if (nb >= nbw) return (64'd1 << nbw) - 64'd1;
      return ((64'd1 << nb) - 64'd1) << off;
   endfunction

   function automatic logic [63:0] exp_wdata(input int nbw, input int nb, input logic [63:0] wd);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < nbw; i++) v[i*8 +: 8] = wd[(i % nb)*8 +: 8];
      return v;
   endfunction

   task automatic check_reset_vals(input int d);
      check("rst_req_ready", req_ready[d], 1);
      check("rst_resp_valid", resp_valid[d], 0);
      check("rst_resp_ale", resp_ale[d], 0);
      check("rst_mem_req", mem_req[d], 0);
      check("rst_mem_we", mem_we[d], 0);
      check("rst_mem_wstrb", o_wstrb(d), 0);
      check("rst_resp_rdata", o_rdata(d), 0);
      check("rst_resp_rd", resp_rd[d], 0);
   endtask

   // One full access; aw/dw/rw are stall cycles on addr_ok, data_ok and resp_ready.
   task automatic txn(input int d, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                      input logic [63:0] rdata, input int aw, input int dw, input int rw,
                      output logic [63:0] g_addr, output logic [63:0] g_strb,
                      output logic [63:0] g_wdata, output logic [63:0] g_rdata);
      int dwid, nbw, nb, off;
      bit ale;
      logic [63:0] e_addr, e_strb, e_wdata, e_rdata;
      dwid = (d == 1) ? 64 : 32;
      nbw  = dwid / 8;
      nb   = 1 << size;
      off  = int'(addr[2:0]) % nbw;
      ale  = (nb > nbw) || ((int'(addr[2:0]) % nb) != 0);
      e_addr  = {32'd0, addr} - 64'(off);
      e_strb  = we ? exp_strb(nbw, nb, off) : 64'd0;
      e_wdata = exp_wdata(nbw, nb, wdata & dmask(dwid));
      e_rdata = (ale || we) ? 64'd0 : exp_load(dwid, nb, uns, off, rdata);
      g_addr = '0; g_strb = '0; g_wdata = '0;

      check("req_ready_idle", req_ready[d], 1);
      req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size; req_unsigned[d] = uns;
      req_addr[d] = addr; req_wdata[d] = wdata; req_rd[d] = rd;
      step;
      req_valid[d] = 1'b0; req_addr[d] = $urandom; req_wdata[d] = {$urandom, $urandom};
      req_rd[d] = 5'($urandom); req_size[d] = 2'($urandom);

      if (!ale) begin
         g_addr = {32'd0, mem_addr[d]}; g_strb = o_wstrb(d); g_wdata = o_wdata(d);
         for (int i = 0; i <= aw; i++) begin
            check("mem_req_addr", mem_req[d], 1);
            check("req_ready_busy", req_ready[d], 0);
            check("mem_addr", {32'd0, mem_addr[d]}, e_addr);
            check("mem_we", mem_we[d], we);
            check("mem_wstrb", o_wstrb(d), e_strb);
            if (we) check("mem_wdata", o_wdata(d), e_wdata);
            mem_addr_ok[d] = (i == aw);
            mem_data_ok[d] = (i < aw) ? 1'($urandom) : 1'b0;
            step;
            mem_addr_ok[d] = 1'b0; mem_data_ok[d] = 1'b0;
         end
         for (int i = 0; i <= dw; i++) begin
            check("mem_req_data", mem_req[d], 0);
            check("resp_valid_data", resp_valid[d], 0);
            mem_rdata[d]   = (i == dw) ? rdata : {$urandom, $urandom};
            mem_data_ok[d] = (i == dw);
            step;
            mem_data_ok[d] = 1'b0; mem_rdata[d] = {$urandom, $urandom};
         end
      end

      g_rdata = o_rdata(d);
      for (int i = 0; i <= rw; i++) begin
         check("resp_valid", resp_valid[d], 1);
         check("resp_ale", resp_ale[d], ale);
         check("resp_rdata", o_rdata(d), e_rdata);
         check("resp_rd", resp_rd[d], rd);
         check("mem_req_resp", mem_req[d], 0);
         check("req_ready_resp", req_ready[d], 0);
         resp_ready[d] = (i == rw);
         step;
         resp_ready[d] = 1'b0;
      end
      check("resp_valid_done", resp_valid[d], 0);
      check("req_ready_done", req_ready[d], 1);
      $display("txn dut%0d we=%0d size=%0d uns=%0d addr=%h rd=%0d ale=%0d resp_rdata=%h",
               dwid, we, size, uns, addr, rd, ale, g_rdata);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] a, s, w, r, rv;
      reset = 1'b1;
      repeat (3) step;
      check_reset_vals(0);
      check_reset_vals(1);
      reset = 1'b0;
      step;

      // Byte loads, signed and unsigned
      txn(0, 0, 2'd0, 0, 32'h1c000003, 64'd0, 5'd7, 64'h80FF1234, 0, 0, 0, a, s, w, r);
      check("lb_addr", a, 64'h1c000000);
      check("lb_signed", r, 64'hFFFFFF80);
      txn(0, 0, 2'd0, 1, 32'h1c000003, 64'd0, 5'd8, 64'h80FF1234, 0, 0, 0, a, s, w, r);
      check("lbu", r, 64'h00000080);

      // Half store
      txn(0, 1, 2'd1, 0, 32'h1c000006, 64'h0000ABCD, 5'd9, 64'd0, 0, 0, 0, a, s, w, r);
      check("sh_addr", a, 64'h1c000004);
      check("sh_strb", s, 64'hC);
      check("sh_wdata", w, 64'hABCDABCD);
      check("sh_rdata", r, 64'd0);

      // Misaligned word load
      txn(0, 0, 2'd2, 0, 32'h1c000002, 64'd0, 5'd21, 64'd0, 0, 0, 1, a, s, w, r);

      // Stalls on every handshake
      txn(0, 0, 2'd1, 0, 32'h1c000102, 64'd0, 5'd3, 64'h8001_7FFE, 3, 2, 2, a, s, w, r);
      check("stall_lh", r, 64'hFFFF8001);

      // 64-bit instance
      rv = {$urandom, $urandom};
      txn(1, 0, 2'd3, 0, 32'h00000008, 64'd0, 5'd1, rv, 0, 0, 0, a, s, w, r);
      check("ld_dword", r, rv);
      txn(1, 0, 2'd2, 0, 32'h0000000C, 64'd0, 5'd2, 64'h8000000112345678, 0, 0, 0, a, s, w, r);
      check("lw_64", r, 64'hFFFFFFFF80000001);
      txn(1, 1, 2'd3, 0, 32'h00000010, 64'h1122334455667788, 5'd4, 64'd0, 0, 0, 0, a, s, w, r);
      check("sd_strb", s, 64'hFF);
      check("sd_wdata", w, 64'h1122334455667788);
      txn(1, 0, 2'd3, 0, 32'h00000014, 64'd0, 5'd5, 64'd0, 0, 0, 0, a, s, w, r);

      // Reset while waiting for read data, then a stray data_ok
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
      req_addr[0] = 32'h1c000010; req_rd[0] = 5'd17;
      step;
      req_valid[0] = 1'b0;
      check("rst_mid_mem_req", mem_req[0], 1);
      mem_addr_ok[0] = 1'b1;
      step;
      mem_addr_ok[0] = 1'b0;
      check("rst_mid_in_data", mem_req[0], 0);
      reset = 1'b1;
      step;
      check_reset_vals(0);
      reset = 1'b0;
      mem_data_ok[0] = 1'b1; mem_rdata[0] = 64'h1234_5678;
      step;
      mem_data_ok[0] = 1'b0;
      check("stray_resp_valid", resp_valid[0], 0);
      check("stray_req_ready", req_ready[0], 1);
      check("stray_mem_req", mem_req[0], 0);
      txn(0, 0, 2'd2, 0, 32'h1c000010, 64'd0, 5'd17, 64'hCAFE_F00D, 0, 0, 0, a, s, w, r);
      check("post_rst_lw", r, 64'hCAFEF00D);

      // Random traffic on both instances
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 80; k++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
            txn(d, 1'($urandom), sz, 1'($urandom), ad, {$urandom, $urandom}, 5'($urandom),
                {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), a, s, w, r);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
